// File: rtl/sdram_arbiter.sv
// Two-port slot arbiter in front of the MiST SDRAM controller. Grants at most one port per
// 8 MHz chipset slot, holds the request for the slot and returns read data at a fixed phase.
module sdram_arbiter #(
   parameter int DATA_PHASE = 5,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk_64,
   input  logic        init,
   input  logic        clk_8,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [23:0] a_addr,
   input  logic [1:0]  a_ds,
   input  logic [15:0] a_din,
   output logic [15:0] a_dout,
   output logic        a_ack,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [23:0] b_addr,
   input  logic [1:0]  b_ds,
   input  logic [15:0] b_din,
   output logic [15:0] b_dout,
   output logic        b_ack,
   output logic        oe,
   output logic        we,
   output logic [23:0] addr,
   output logic [1:0]  ds,
   output logic [15:0] din,
   input  logic [15:0] dout
);

   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

   localparam logic [2:0] PH_DATA = 3'(DATA_PHASE);
   localparam logic [2:0] PH_MAX  = 3'd7;

   logic        clk_8d_q, clk_8d_d;
   logic [2:0]  ph_q, ph_d;
   logic        busy_q, busy_d;
   port_e       gnt_q, gnt_d;
   port_e       last_q, last_d;
   logic        oe_q, oe_d;
   logic        we_q, we_d;
   logic [23:0] addr_q, addr_d;
   logic [1:0]  ds_q, ds_d;
   logic [15:0] din_q, din_d;
   logic [15:0] a_dout_q, a_dout_d;
   logic [15:0] b_dout_q, b_dout_d;
   logic        a_ack_q, a_ack_d;
   logic        b_ack_q, b_ack_d;

   logic        slot_edge;
   logic        any_req;
   logic        done;
   port_e       pick;

   assign slot_edge = clk_8 & ~clk_8d_q;
   assign any_req   = a_req | b_req;
   assign done      = busy_q && (ph_q == PH_DATA);

   // Round-robin hands contention to whichever port did not win the last granted slot.
   always_comb begin
      pick = PORT_A;
      if (a_req && b_req) begin
         if (FIXED_PRIO) pick = PORT_A;
         else            pick = (last_q == PORT_A) ? PORT_B : PORT_A;
      end else if (b_req) begin
         pick = PORT_B;
      end
   end

   always_comb begin
      clk_8d_d = clk_8;
      ph_d     = ph_q;
      busy_d   = busy_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      oe_d     = oe_q;
      we_d     = we_q;
      addr_d   = addr_q;
      ds_d     = ds_q;
      din_d    = din_q;
      a_dout_d = a_dout_q;
      b_dout_d = b_dout_q;
      a_ack_d  = 1'b0;
      b_ack_d  = 1'b0;

      if (slot_edge)          ph_d = 3'd0;
      else if (ph_q != PH_MAX) ph_d = ph_q + 3'd1;

      if (done) begin
         busy_d = 1'b0;
         if (gnt_q == PORT_A) begin
            a_ack_d = 1'b1;
            if (!we_q) a_dout_d = dout;
         end else begin
            b_ack_d = 1'b1;
            if (!we_q) b_dout_d = dout;
         end
      end

      // Downstream signals only move at slot start; an idle slot keeps addr/din.
      if (slot_edge) begin
         if (any_req) begin
            busy_d = 1'b1;
            gnt_d  = pick;
            last_d = pick;
            if (pick == PORT_A) begin
               oe_d   = ~a_we;
               we_d   = a_we;
               addr_d = a_addr;
               ds_d   = a_ds;
               din_d  = a_din;
            end else begin
               oe_d   = ~b_we;
               we_d   = b_we;
               addr_d = b_addr;
               ds_d   = b_ds;
               din_d  = b_din;
            end
         end else begin
            busy_d = 1'b0;
            oe_d   = 1'b0;
            we_d   = 1'b0;
            ds_d   = 2'b00;
         end
      end
   end

   // clk_8d resets high so a clk_8 already high at release is not taken as a slot edge.
   always_ff @(posedge clk_64) begin
      if (init) begin
         clk_8d_q <= 1'b1;
         ph_q     <= PH_MAX;
         busy_q   <= 1'b0;
         gnt_q    <= PORT_A;
         last_q   <= PORT_B;
         oe_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         ds_q     <= '0;
         din_q    <= '0;
         a_dout_q <= '0;
         b_dout_q <= '0;
         a_ack_q  <= 1'b0;
         b_ack_q  <= 1'b0;
      end else begin
         clk_8d_q <= clk_8d_d;
         ph_q     <= ph_d;
         busy_q   <= busy_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         ds_q     <= ds_d;
         din_q    <= din_d;
         a_dout_q <= a_dout_d;
         b_dout_q <= b_dout_d;
         a_ack_q  <= a_ack_d;
         b_ack_q  <= b_ack_d;
      end
   end

   assign oe     = oe_q;
   assign we     = we_q;
   assign addr   = addr_q;
   assign ds     = ds_q;
   assign din    = din_q;
   assign a_dout = a_dout_q;
   assign b_dout = b_dout_q;
   assign a_ack  = a_ack_q;
   assign b_ack  = b_ack_q;

endmodule
